// File: rtl/fifo_stream_drain.sv
`timescale 1ns/1ps
// fifo_stream_drain
//   Read-side adapter for sync_fifo. It turns read_en/empty/registered-rdata into
//   a valid/ready stream with m_last_o framing every BURST_LEN accepted beats.
//   A 2-entry prefetch buffer covers the FIFO's one-cycle read latency, so the
//   adapter sustains one word per cycle while m_ready_i stays high.
//   Optional feature macro: DRAIN_STATS_EN adds the saturating stat_words_o count.
module fifo_stream_drain #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned CNT_W     = 3
`ifdef DRAIN_STATS_EN
  , parameter int unsigned STAT_W  = 16
`endif
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             fifo_read_en_o,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_last_o,
  input  logic             m_ready_i
`ifdef DRAIN_STATS_EN
  , output logic [STAT_W-1:0] stat_words_o
`endif
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] buf_d [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             pop;
  logic             cap;
  logic [2:0]       level;

  // Stream outputs come straight from registers.
  always_comb begin
    m_valid_o = (occ_q != 2'd0);
    m_data_o  = buf_q[head_q];
    m_last_o  = m_valid_o & (beat_cnt_q == LAST_BEAT);
  end

  // Read issue: only request when the word can still land in the buffer after
  // this cycle's pop; never while empty, flushing or held in reset.
  always_comb begin
    pop            = m_valid_o & m_ready_i;
    cap            = inflight_q;
    level          = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    fifo_read_en_o = rst_n_i & ~fifo_empty_i & ~flush_i & (level < 3'd2);
  end

  // Next-state for buffer, in-flight tracking and beat framing.
  always_comb begin
    buf_d      = buf_q;
    head_d     = head_q ^ pop;
    tail_d     = tail_q ^ cap;
    occ_d      = occ_q + {1'b0, cap} - {1'b0, pop};
    inflight_d = fifo_read_en_o;
    beat_cnt_d = beat_cnt_q;
    if (cap) begin
      buf_d[tail_q] = fifo_rdata_i;
    end
    if (pop) begin
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + CNT_W'(1);
    end
    // A flush discards buffered and in-flight words; a pop in the same cycle
    // has already completed downstream, only its framing advance is dropped.
    if (flush_i) begin
      occ_d      = '0;
      head_d     = 1'b0;
      tail_d     = 1'b0;
      beat_cnt_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      buf_q      <= buf_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef DRAIN_STATS_EN
  logic [STAT_W-1:0] stat_q, stat_d;

  // Accepted-word count, saturating; survives flush.
  always_comb begin
    stat_d = stat_q;
    if (pop && (stat_q != '1)) begin
      stat_d = stat_q + STAT_W'(1);
    end
  end

  // Statistics register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_words_o = stat_q;
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
`timescale 1ns/1ps
// Bench for fifo_stream_drain: a behavioural sync_fifo drives the read side and
// a scoreboard queue holds every word expected on the stream, in order.
module tb_fifo_stream_drain;
  localparam int W  = 32;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          flush_i;
  logic          fifo_empty_i;
  logic [W-1:0]  fifo_rdata_i;
  logic          fifo_read_en_o;
  logic          m_valid_o;
  logic [W-1:0]  m_data_o;
  logic          m_last_o;
  logic          m_ready_i;
`ifdef DRAIN_STATS_EN
  logic [3:0]    stat_words_o;
`endif

  always #5 clk = ~clk;

  fifo_stream_drain #(
    .WIDTH    (W),
    .BURST_LEN(BL),
    .CNT_W    (3)
`ifdef DRAIN_STATS_EN
    , .STAT_W (4)
`endif
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .flush_i       (flush_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_rdata_i  (fifo_rdata_i),
    .fifo_read_en_o(fifo_read_en_o),
    .m_valid_o     (m_valid_o),
    .m_data_o      (m_data_o),
    .m_last_o      (m_last_o),
    .m_ready_i     (m_ready_i)
`ifdef DRAIN_STATS_EN
    , .stat_words_o(stat_words_o)
`endif
  );

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  int           bcnt  = 0;
  int           npop  = 0;
  logic [W-1:0] fifo_q [$];
  logic [W-1:0] exp_q  [$];
  bit           s_re, s_valid, s_pop;

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty_i = 1'b0;
  endtask

  task automatic model_clear();
    fifo_q.delete();
    exp_q.delete();
    fifo_rdata_i = '0;
    fifo_empty_i = 1'b1;
    bcnt         = 0;
  endtask

  // One clock: observe at the falling edge (scoreboard pop, invariants), then
  // model the FIFO's registered read just after the rising edge.
  task automatic step();
    logic         re;
    logic [W-1:0] e;
    logic         exp_last;
    @(negedge clk);
    re      = fifo_read_en_o;
    s_re    = re;
    s_valid = m_valid_o;
    s_pop   = m_valid_o & m_ready_i;
    if (rst_n_i) begin
      total++;
      if (fifo_read_en_o && fifo_empty_i) begin
        bad++;
        $display("FAIL read_while_empty: read_en=%0b empty=%0b required read_en=0", fifo_read_en_o, fifo_empty_i);
      end
      total++;
      if ((int'(dut.occ_q) + int'(dut.inflight_q)) > 2) begin
        bad++;
        $display("FAIL occupancy: occ+inflight=%0d required <=2", int'(dut.occ_q) + int'(dut.inflight_q));
      end
      if (s_pop) begin
        npop++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got 0x%08h with scoreboard empty", m_data_o);
        end else begin
          e = exp_q.pop_front();
          if (m_data_o !== e) begin
            bad++;
            $display("FAIL beat_data: got 0x%08h required 0x%08h", m_data_o, e);
          end
        end
        exp_last = (bcnt == BL - 1);
        total++;
        if (m_last_o !== exp_last) begin
          bad++;
          $display("FAIL beat_last: got %0b required %0b (beat %0d)", m_last_o, exp_last, bcnt);
        end
        bcnt = (bcnt == BL - 1) ? 0 : bcnt + 1;
      end
      if (flush_i) bcnt = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (re && fifo_q.size() > 0) fifo_rdata_i = fifo_q.pop_front();
    fifo_empty_i = (fifo_q.size() == 0);
  endtask

  task automatic test_reset();
    rst_n_i   = 1'b0;
    flush_i   = 1'b0;
    m_ready_i = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    total++;
    if (m_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b required 0", m_valid_o); end
    total++;
    if (m_data_o !== '0) begin bad++; $display("FAIL rst_data: got 0x%08h required 0", m_data_o); end
    total++;
    if (m_last_o !== 1'b0) begin bad++; $display("FAIL rst_last: got %0b required 0", m_last_o); end
    total++;
    if (fifo_read_en_o !== 1'b0) begin bad++; $display("FAIL rst_read_en: got %0b required 0", fifo_read_en_o); end
    // Traffic, then reset in the middle of it.
    m_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(W'(i));
    repeat (4) step();
    rst_n_i = 1'b0;
    #1;
    total++;
    if (m_valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b required 0", m_valid_o); end
    total++;
    if (m_data_o !== '0) begin bad++; $display("FAIL midrst_data: got 0x%08h required 0", m_data_o); end
    total++;
    if (fifo_read_en_o !== 1'b0) begin bad++; $display("FAIL midrst_read_en: got %0b required 0", fifo_read_en_o); end
    total++;
    if (dut.occ_q !== 2'd0) begin bad++; $display("FAIL midrst_occ: got %0d required 0", dut.occ_q); end
    total++;
    if (dut.beat_cnt_q !== 3'd0) begin bad++; $display("FAIL midrst_beat: got %0d required 0", dut.beat_cnt_q); end
    model_clear();
    repeat (2) step();
    rst_n_i = 1'b1;
  endtask

  task automatic test_stream();
    int first_re = -1, first_v = -1, first_p = -1, last_p = -1, n0;
    m_ready_i = 1'b1;
    n0 = npop;
    for (int i = 1; i <= 16; i++) push_word(W'(i));
    for (int k = 0; k < 40; k++) begin
      step();
      if (s_re && first_re < 0) first_re = k;
      if (s_valid && first_v < 0) first_v = k;
      if (s_pop) begin
        if (first_p < 0) first_p = k;
        last_p = k;
      end
    end
    total++;
    if (first_re < 0 || first_v - first_re != 2) begin
      bad++; $display("FAIL stream_latency: got %0d cycles required 2", first_v - first_re);
    end
    total++;
    if (npop - n0 != 16) begin bad++; $display("FAIL stream_count: got %0d beats required 16", npop - n0); end
    total++;
    if (last_p - first_p != 15) begin
      bad++; $display("FAIL stream_back_to_back: got span %0d required 15", last_p - first_p);
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL stream_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int nre = 0, n0;
    m_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(W'(i));
    repeat (10) begin
      step();
      if (s_re) nre++;
    end
    total++;
    if (nre != 2) begin bad++; $display("FAIL bp_reads: got %0d required 2", nre); end
    total++;
    if (m_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid: got %0b required 1", m_valid_o); end
    total++;
    if (m_data_o !== W'(1)) begin bad++; $display("FAIL bp_hold: got 0x%08h required 0x00000001", m_data_o); end
    total++;
    if (fifo_q.size() != 3) begin bad++; $display("FAIL bp_unread: got %0d required 3", fifo_q.size()); end
    m_ready_i = 1'b1;
    n0 = npop;
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) step();
    total++;
    if (exp_q.size() != 0 || npop - n0 != 5) begin
      bad++; $display("FAIL bp_release: got %0d beats, %0d left required 5, 0", npop - n0, exp_q.size());
    end
  endtask

  task automatic test_random();
    int n = 0;
    for (int k = 0; k < 3000 && (n < 200 || exp_q.size() != 0); k++) begin
      if (n < 200 && $urandom_range(0, 1) == 1) begin
        push_word($urandom);
        n++;
      end
      m_ready_i = ($urandom_range(0, 1) == 1);
      step();
    end
    total++;
    if (n != 200 || exp_q.size() != 0) begin
      bad++; $display("FAIL random_drain: got %0d pushed, %0d left required 200, 0", n, exp_q.size());
    end
  endtask

  task automatic test_flush();
    int drop;
    m_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) push_word(W'(32'h100 + i));
    repeat (3) step();
    m_ready_i = 1'b0;
    flush_i   = 1'b1;
    drop = exp_q.size() - fifo_q.size();
    total++;
    if (drop != 2 || dut.occ_q !== 2'd1 || dut.inflight_q !== 1'b1) begin
      bad++; $display("FAIL flush_setup: got drop=%0d occ=%0d inflight=%0b required 2,1,1", drop, dut.occ_q, dut.inflight_q);
    end
    repeat (drop) void'(exp_q.pop_front());
    step();
    flush_i = 1'b0;
    total++;
    if (s_re !== 1'b0) begin bad++; $display("FAIL flush_no_read: got read_en=%0b required 0", s_re); end
    total++;
    if (m_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid: got %0b required 0", m_valid_o); end
    total++;
    if (dut.beat_cnt_q !== 3'd0) begin bad++; $display("FAIL flush_beat: got %0d required 0", dut.beat_cnt_q); end
    m_ready_i = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL flush_drain: got %0d left required 0", exp_q.size()); end
  endtask

`ifdef DRAIN_STATS_EN
  task automatic test_stats();
    rst_n_i = 1'b0;
    #1;
    model_clear();
    step();
    rst_n_i   = 1'b1;
    m_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) push_word(W'(32'h200 + i));
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
    repeat (2) step();
    total++;
    if (stat_words_o !== 4'd10) begin bad++; $display("FAIL stats_count: got %0d required 10", stat_words_o); end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    total++;
    if (stat_words_o !== 4'd10) begin bad++; $display("FAIL stats_flush: got %0d required 10", stat_words_o); end
    for (int i = 0; i < 10; i++) push_word(W'(32'h300 + i));
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
    repeat (2) step();
    total++;
    if (stat_words_o !== 4'd15) begin bad++; $display("FAIL stats_saturate: got %0d required 15", stat_words_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_flush();
`ifdef DRAIN_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
